gnn_layer_seq: RTL

//  Parametrised, sequential two-layer graph network engine.
//  - Layer 1: adjacency-masked neighbour aggregation, dense N_IN->N_HID, ReLU.
//  - Layer 2: aggregation of hidden vectors, dense N_HID->N_OUT.
//  - Node count, feature widths and graph topology are runtime/parameter choices, not hard-wired.
//  - Processes one node per cycle per layer, with valid/ready handshakes on both sides.

---
 rtl/gnn_layer_seq_pkg.sv | 49 ++++
 rtl/gnn_layer_seq_if.sv | 31 +++
 rtl/gnn_row_mac.sv | 21 ++
 rtl/gnn_layer_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/gnn_layer_seq_pkg.sv
// Shared types and width/clamp helpers for the sequential two-layer graph engine.
// Clamping helpers are only referenced when GNN_SAT_EN is defined.
package gnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        L1   = 2'd1,
        L2   = 2'd2,
        DONE = 2'd3
    } state_t;

    // Aggregated input feature width: room for N_NODES additions.
    function automatic int calc_aw(input int iw, input int n_nodes);
        return iw + $clog2(n_nodes);
    endfunction

    // Full-precision dot-product width for n_terms products of aw x ww.
    function automatic int calc_pw(input int aw, input int ww, input int n_terms);
        return aw + ww + $clog2(n_terms) + 1;
    endfunction

    // Aggregated hidden width; the extra bit makes the unsigned sum signed.
    function automatic int calc_haw(input int hw, input int n_nodes);
        return hw + $clog2(n_nodes) + 1;
    endfunction

    function automatic int calc_yfw(input int hw, input int ww, input int n_nodes, input int n_hid);
        return calc_pw(calc_haw(hw, n_nodes), ww, n_hid);
    endfunction

    function automatic logic signed [63:0] sat_u(input logic signed [63:0] v, input int w);
        logic signed [63:0] max_v;
        max_v = (64'sd1 <<< w) - 64'sd1;
        if (v < 64'sd0) return 64'sd0;
        if (v > max_v) return max_v;
        return v;
    endfunction

    function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int w);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (w - 1));
        if (v > max_v) return max_v;
        if (v < min_v) return min_v;
        return v;
    endfunction

endpackage

// File: rtl/gnn_layer_seq_if.sv
// Job bundle and result handshake of gnn_layer_seq.
// Both sides use valid/ready: a transfer happens on a clock edge where valid and ready are both high.
interface gnn_layer_seq_if #(
    parameter int N_NODES = 4,
    parameter int N_IN    = 4,
    parameter int N_HID   = 4,
    parameter int N_OUT   = 2,
    parameter int IW      = 5,
    parameter int WW      = 5,
    parameter int OW      = 21
) ();
    logic                          in_valid;
    logic                          in_ready;
    logic [N_NODES*N_IN*IW-1:0]    x;
    logic [N_HID*N_IN*WW-1:0]      w1;
    logic [N_OUT*N_HID*WW-1:0]     w2;
    logic [N_NODES*N_NODES-1:0]    adj;
    logic                          out_valid;
    logic                          out_ready;
    logic [N_NODES*N_OUT*OW-1:0]   y;

    modport master (
        output in_valid, x, w1, w2, adj, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, x, w1, w2, adj, out_ready,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/gnn_row_mac.sv
// Signed dot product of one aggregated vector with one weight row, kept at full precision.
module gnn_row_mac
    import gnn_pkg::*;
#(
    parameter int N_TERMS = 4,
    parameter int AWID    = 7,
    parameter int WWID    = 5,
    localparam int DWID   = calc_pw(AWID, WWID, N_TERMS)
) (
    input  logic [N_TERMS*AWID-1:0] i_vec,
    input  logic [N_TERMS*WWID-1:0] i_wrow,
    output logic signed [DWID-1:0]  o_dot
);
    always_comb begin
        o_dot = '0;
        for (int t = 0; t < N_TERMS; t++) begin
            o_dot = o_dot + DWID'($signed(i_vec[t*AWID +: AWID])) *
                            DWID'($signed(i_wrow[t*WWID +: WWID]));
        end
    end
endmodule

// File: rtl/gnn_layer_seq.sv
// Sequential two-layer graph network: one node per cycle through L1 (aggregate, dense, ReLU) then L2.
// Optional GNN_SAT_EN clamps hidden and output values instead of truncating them.
module gnn_layer_seq
    import gnn_pkg::*;
#(
    parameter int N_NODES = 4,
    parameter int N_IN    = 4,
    parameter int N_HID   = 4,
    parameter int N_OUT   = 2,
    parameter int IW      = 5,
    parameter int WW      = 5,
    parameter int HW      = 13,
    parameter int OW      = 21
) (
    input  logic           clk,
    input  logic           rst,
    gnn_layer_seq_if.slave bus,
    output state_t         o_state
);
    localparam int AW  = calc_aw(IW, N_NODES);
    localparam int HAW = calc_haw(HW, N_NODES);
    localparam int PW1 = calc_pw(AW, WW, N_IN);
    localparam int YFW = calc_yfw(HW, WW, N_NODES, N_HID);
    localparam int CW  = (N_NODES > 1) ? $clog2(N_NODES) : 1;

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [CW-1:0]                 r_cnt;
    logic [N_NODES*N_IN*IW-1:0]    r_x;
    logic [N_HID*N_IN*WW-1:0]      r_w1;
    logic [N_OUT*N_HID*WW-1:0]     r_w2;
    logic [N_NODES*N_NODES-1:0]    r_adj;
    logic [N_NODES*N_HID*HW-1:0]   r_h;
    logic [N_NODES*N_OUT*OW-1:0]   r_y;

    logic                          w_in_ready;
    logic                          w_out_valid;
    logic                          w_accept;
    logic                          w_last;
    logic [N_IN*AW-1:0]            w_agg1;
    logic [N_HID*HAW-1:0]          w_agg2;
    logic signed [PW1-1:0]         w_dot1 [N_HID];
    logic signed [YFW-1:0]         w_dot2 [N_OUT];
    logic [N_HID*HW-1:0]           w_h_row;
    logic [N_OUT*OW-1:0]           w_y_row;

    assign w_last   = (r_cnt == CW'(N_NODES - 1));
    assign w_accept = bus.in_valid && w_in_ready;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_state_nxt = L1;
            L1:      if (w_last)        w_state_nxt = L2;
            L2:      if (w_last)        w_state_nxt = DONE;
            DONE:    if (bus.out_ready) w_state_nxt = IDLE;
            default:                    w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_in_ready  = (r_state == IDLE);
        w_out_valid = (r_state == DONE);
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.y         = r_y;
    assign o_state       = r_state;

    // ---------------- Aggregation over the current node's adjacency row ----------------
    always_comb begin
        logic signed [AW-1:0] acc;
        w_agg1 = '0;
        for (int i = 0; i < N_IN; i++) begin
            acc = '0;
            for (int j = 0; j < N_NODES; j++) begin
                if (r_adj[int'(r_cnt)*N_NODES + j])
                    acc = acc + AW'($signed(r_x[(j*N_IN + i)*IW +: IW]));
            end
            w_agg1[i*AW +: AW] = acc;
        end
    end

    // Hidden values are non-negative, so they are zero-extended before the signed sum.
    always_comb begin
        logic signed [HAW-1:0] acc;
        w_agg2 = '0;
        for (int k = 0; k < N_HID; k++) begin
            acc = '0;
            for (int j = 0; j < N_NODES; j++) begin
                if (r_adj[int'(r_cnt)*N_NODES + j])
                    acc = acc + $signed(HAW'(r_h[(j*N_HID + k)*HW +: HW]));
            end
            w_agg2[k*HAW +: HAW] = acc;
        end
    end

    // ---------------- Dense rows ----------------
    for (genvar k = 0; k < N_HID; k++) begin : g_l1_mac
        gnn_row_mac #(
            .N_TERMS (N_IN),
            .AWID    (AW),
            .WWID    (WW)
        ) u_mac (
            .i_vec  (w_agg1),
            .i_wrow (r_w1[k*N_IN*WW +: N_IN*WW]),
            .o_dot  (w_dot1[k])
        );
    end

    for (genvar o = 0; o < N_OUT; o++) begin : g_l2_mac
        gnn_row_mac #(
            .N_TERMS (N_HID),
            .AWID    (HAW),
            .WWID    (WW)
        ) u_mac (
            .i_vec  (w_agg2),
            .i_wrow (r_w2[o*N_HID*WW +: N_HID*WW]),
            .o_dot  (w_dot2[o])
        );
    end

    // ---------------- ReLU and single narrowing at store time ----------------
    always_comb begin
        logic signed [63:0] v;
        w_h_row = '0;
        for (int k = 0; k < N_HID; k++) begin
            v = 64'(w_dot1[k]);
            if (v < 64'sd0) v = 64'sd0;
`ifdef GNN_SAT_EN
            v = sat_u(v, HW);
`endif
            w_h_row[k*HW +: HW] = v[HW-1:0];
        end
    end

    always_comb begin
        logic signed [63:0] v;
        w_y_row = '0;
        for (int o = 0; o < N_OUT; o++) begin
            v = 64'(w_dot2[o]);
`ifdef GNN_SAT_EN
            v = sat_s(v, OW);
`endif
            w_y_row[o*OW +: OW] = v[OW-1:0];
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_x   <= '0;
            r_w1  <= '0;
            r_w2  <= '0;
            r_adj <= '0;
            r_h   <= '0;
            r_y   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_x   <= bus.x;
                        r_w1  <= bus.w1;
                        r_w2  <= bus.w2;
                        r_adj <= bus.adj;
                        r_cnt <= '0;
                    end
                end
                L1: begin
                    r_h[int'(r_cnt)*N_HID*HW +: N_HID*HW] <= w_h_row;
                    r_cnt <= w_last ? '0 : r_cnt + CW'(1);
                end
                L2: begin
                    r_y[int'(r_cnt)*N_OUT*OW +: N_OUT*OW] <= w_y_row;
                    r_cnt <= w_last ? '0 : r_cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
